// File: rtl/dll_lock_ctrl_if.sv
// Bundles the handshake between the FMDLL lock sequencer, its phase detector
// and the delay line.
//   start      request to (re)start acquisition (1-cycle pulse)
//   comp       phase decision, synchronous to clk4; 1 = lead (raise code)
//   code       delay-line control code
//   busy       high while the binary search runs
//   locked     high while lock is declared
//   lock_lost  1-cycle pulse when lock is lost and the search re-runs
// The slave modport is the sequencer's view. The master modport is the
// surrounding logic (phase detector and controller) or a bench.
interface dll_lock_ctrl_if #(
  parameter int N_BITS = 10
);
  logic              start;
  logic              comp;
  logic [N_BITS-1:0] code;
  logic              busy;
  logic              locked;
  logic              lock_lost;

  modport master (output start, comp, input code, busy, locked, lock_lost);
  modport slave  (input start, comp, output code, busy, locked, lock_lost);
endinterface

// File: rtl/dll_lock_ctrl.sv
// Lock sequencer for the FMDLL delay line.
// On start, it runs a settled binary search on the delay code, using the
// phase-comparator decision. It then tracks the phase in +/-1 steps. It
// declares lock after sustained dithering, and it re-runs the search when
// the dithering turns into a steady drift.
//   clk4  system clock; all logic updates on the rising edge
//   rst   asynchronous reset, active high
//   bus   dll_lock_ctrl_if slave: start/comp in; code/busy/locked/lock_lost out
//
//   state  | meaning
//   IDLE   | code parked at mid-scale, waiting for start
//   SEARCH | binary search, one bit resolved per settled decision
//   TRACK  | +/-1 tracking, counting consecutive direction reversals
//   LOCKED | +/-1 tracking, counting consecutive same-direction steps
module dll_lock_ctrl #(
  parameter int N_BITS     = 10,
  parameter int SETTLE_CYC = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic           clk4,
  input  logic           rst,
  dll_lock_ctrl_if.slave bus
);

  localparam int TW = $clog2(SETTLE_CYC + 1);
  localparam int KW = $clog2(N_BITS);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(UNLOCK_CNT + 1);

  localparam logic [N_BITS-1:0] CODE_MID   = {1'b1, {(N_BITS-1){1'b0}}};
  localparam logic [N_BITS-1:0] CODE_MAX   = {N_BITS{1'b1}};
  localparam logic [TW-1:0]     TMR_RELOAD = TW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, TRACK, LOCKED} state_t;

  state_t            state, state_n;
  logic [N_BITS-1:0] code, code_n;
  logic [KW-1:0]     k, k_n;
  logic [TW-1:0]     timer, timer_n;
  logic [RW-1:0]     rev_cnt, rev_n;
  logic [SW-1:0]     same_cnt, same_n;
  logic              prev_dir, prev_n;
  logic              has_prev, has_prev_n;
  logic              lost, lost_n;
  logic              go_search;
  logic              dec;
  logic              reversal;

  // A decision is taken on the edge where the settle timer has run out.
  assign dec      = (timer == '0);
  // The first step after entering TRACK has no previous direction. It can
  // never count as a reversal.
  assign reversal = has_prev && (bus.comp != prev_dir);

  always_ff @(posedge clk4 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      code     <= CODE_MID;
      k        <= '0;
      timer    <= '0;
      rev_cnt  <= '0;
      same_cnt <= '0;
      prev_dir <= 1'b0;
      has_prev <= 1'b0;
      lost     <= 1'b0;
    end else begin
      state    <= state_n;
      code     <= code_n;
      k        <= k_n;
      timer    <= timer_n;
      rev_cnt  <= rev_n;
      same_cnt <= same_n;
      prev_dir <= prev_n;
      has_prev <= has_prev_n;
      lost     <= lost_n;
    end
  end

  always_comb begin
    state_n    = state;
    code_n     = code;
    k_n        = k;
    timer_n    = timer;
    rev_n      = rev_cnt;
    same_n     = same_cnt;
    prev_n     = prev_dir;
    has_prev_n = has_prev;
    lost_n     = 1'b0;
    go_search  = 1'b0;

    // The timer reloads on every decision, whether or not the code moves.
    // A saturated step therefore keeps the decision rate.
    if (state != IDLE) begin
      timer_n = dec ? TMR_RELOAD : timer - TW'(1);
    end

    case (state)
      IDLE: begin
        if (bus.start) go_search = 1'b1;
      end

      SEARCH: begin
        if (dec) begin
          if (!bus.comp) code_n[k] = 1'b0;
          if (k != '0) begin
            code_n[k - KW'(1)] = 1'b1;
            k_n                = k - KW'(1);
          end else begin
            state_n    = TRACK;
            has_prev_n = 1'b0;
            rev_n      = '0;
          end
        end
      end

      TRACK, LOCKED: begin
        if (bus.start) begin
          go_search = 1'b1;
        end else if (dec) begin
          if (bus.comp) code_n = (code == CODE_MAX) ? code : code + N_BITS'(1);
          else          code_n = (code == '0)       ? code : code - N_BITS'(1);
          prev_n     = bus.comp;
          has_prev_n = 1'b1;
          if (state == TRACK) begin
            rev_n = reversal ? rev_cnt + RW'(1) : '0;
            if (rev_n == RW'(LOCK_CNT)) begin
              state_n = LOCKED;
              same_n  = '0;
            end
          end else begin
            same_n = reversal ? '0 : same_cnt + SW'(1);
            if (same_n == SW'(UNLOCK_CNT)) begin
              go_search = 1'b1;
              lost_n    = 1'b1;
            end
          end
        end
      end

      default: state_n = IDLE;
    endcase

    // Common entry into SEARCH from IDLE, a restart, or lock loss.
    if (go_search) begin
      state_n    = SEARCH;
      code_n     = CODE_MID;
      k_n        = KW'(N_BITS - 1);
      timer_n    = TMR_RELOAD;
      rev_n      = '0;
      same_n     = '0;
      prev_n     = 1'b0;
      has_prev_n = 1'b0;
    end
  end

  assign bus.code      = code;
  assign bus.busy      = (state == SEARCH);
  assign bus.locked    = (state == LOCKED);
  assign bus.lock_lost = lost;

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Directed bench for dll_lock_ctrl with N_BITS=10, SETTLE_CYC=4,
// LOCK_CNT=8 and UNLOCK_CNT=4. A simple phase-detector model drives comp
// from the current code: comp = (code <= target), or comp is forced to 1.
module tb_dll_lock_ctrl;
  logic       clk4 = 1'b0;
  logic       rst;
  logic       comp_force;
  logic [9:0] target;
  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;

  dll_lock_ctrl_if #(.N_BITS(10)) bus ();

  dll_lock_ctrl #(
    .N_BITS(10), .SETTLE_CYC(4), .LOCK_CNT(8), .UNLOCK_CNT(4)
  ) dut (
    .clk4 (clk4),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk4 = ~clk4;
  always @(posedge clk4) cyc <= cyc + 1;

  always_comb bus.comp = comp_force ? 1'b1 : (bus.code <= target);

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start across exactly one rising edge. The task returns on the
  // falling edge that follows that edge.
  task automatic do_start();
    @(negedge clk4) bus.start = 1'b1;
    @(negedge clk4) bus.start = 1'b0;
  endtask

  // Counts busy-high samples, starting on the falling edge after the start edge.
  task automatic wait_search(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy) break;
      n++;
      @(negedge clk4);
    end
  endtask

  int n, t0, idx, bad;
  int seen [4];
  logic [9:0] last;

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    comp_force = 1'b0;
    target     = 10'd613;

    // Reset state
    #2;
    check("rst_code",   bus.code,      512);
    check("rst_busy",   bus.busy,      0);
    check("rst_locked", bus.locked,    0);
    check("rst_lost",   bus.lock_lost, 0);
    @(negedge clk4); @(negedge clk4);
    rst = 1'b0;
    repeat (3) @(negedge clk4);
    check("idle_busy", bus.busy, 0);
    check("idle_code", bus.code, 512);

    // Reset mid-search: asynchronous return to mid-scale
    do_start();
    check("srch_busy", bus.busy, 1);
    repeat (4) @(negedge clk4);
    check("srch_bit8", bus.code, 768);
    #2 rst = 1'b1;
    #1;
    check("arst_code",   bus.code,   512);
    check("arst_busy",   bus.busy,   0);
    check("arst_locked", bus.locked, 0);
    @(negedge clk4) rst = 1'b0;
    repeat (8) @(negedge clk4);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_code", bus.code, 512);

    // Search to 613: 40 busy cycles
    do_start();
    wait_search(n);
    check("srch_len",  n,        40);
    check("srch_code", bus.code, 613);

    // Tracking dithers between 613 and 614. Lock comes 36 cycles after TRACK entry.
    t0 = cyc; bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.locked) break;
      if (bus.code != 10'd613 && bus.code != 10'd614) bad++;
      @(negedge clk4);
    end
    check("dither_range", bad,      0);
    check("lock_time",    cyc - t0, 36);
    check("lock_locked",  bus.locked, 1);
    check("lock_busy",    bus.busy, 0);
    check("lock_code",    bus.code, 614);

    // Lock loss: forced lead gives 615, 616, 617, then the search restarts.
    comp_force = 1'b1;
    t0 = cyc; idx = 0; last = bus.code;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk4);
      if (bus.lock_lost) break;
      if (bus.code != last && idx < 4) begin
        seen[idx] = bus.code;
        idx++;
      end
      last = bus.code;
    end
    check("loss_steps",  idx,      3);
    check("loss_c0",     seen[0],  615);
    check("loss_c1",     seen[1],  616);
    check("loss_c2",     seen[2],  617);
    check("loss_time",   cyc - t0, 16);
    check("loss_pulse",  bus.lock_lost, 1);
    check("loss_code",   bus.code, 512);
    check("loss_busy",   bus.busy, 1);
    check("loss_locked", bus.locked, 0);
    t0 = cyc;
    @(negedge clk4);
    check("loss_pulse_w", bus.lock_lost, 0);

    // Saturation: comp stays 1. A start pulse mid-search is ignored.
    repeat (10) @(negedge clk4);
    do_start();
    wait_search(n);
    check("sat_len",  cyc - t0, 40);
    check("sat_code", bus.code, 1023);
    repeat (100) @(negedge clk4);
    check("sat_hold",   bus.code,   1023);
    check("sat_nolock", bus.locked, 0);
    check("sat_busy",   bus.busy,   0);

    // Restart from TRACK toward the bottom of the range
    comp_force = 1'b0;
    target     = 10'd0;
    do_start();
    check("trk_restart_code", bus.code, 512);
    wait_search(n);
    check("zero_len",  n,        40);
    check("zero_code", bus.code, 0);

    // Acquire lock at 613, then restart while LOCKED
    target = 10'd613;
    do_start();
    wait_search(n);
    check("re_code", bus.code, 613);
    for (int i = 0; i < 100; i++) begin
      if (bus.locked) break;
      @(negedge clk4);
    end
    check("re_locked", bus.locked, 1);
    do_start();
    check("rs_locked", bus.locked,    0);
    check("rs_lost",   bus.lock_lost, 0);
    check("rs_busy",   bus.busy,      1);
    check("rs_code",   bus.code,      512);
    @(negedge clk4);
    check("rs_lost2",  bus.lock_lost, 0);
    wait_search(n);
    check("rs_len",  n,        39);
    check("rs_code_end", bus.code, 613);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
